mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_if.sv | 24 ++
 rtl/mem_lsu.sv | 203 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the memory port (slave).
`ifndef RegBus
`define RegBus 32
`endif

interface mem_lsu_if;
   logic               dbus_req_o;
   logic               dbus_we_o;
   logic [3:0]         dbus_be_o;
   logic [`RegBus-1:0] dbus_addr_o;
   logic [`RegBus-1:0] dbus_wdata_o;
   logic [`RegBus-1:0] dbus_rdata_i;
   logic               dbus_ack_i;

   modport master (
      output dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o,
      input  dbus_rdata_i, dbus_ack_i
   );

   modport slave (
      input  dbus_req_o, dbus_we_o, dbus_be_o, dbus_addr_o, dbus_wdata_o,
      output dbus_rdata_i, dbus_ack_i
   );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: holds the pipeline while one data-bus access is in
// flight and returns the write-back triple one cycle after EX.
//
// state | meaning
// IDLE  | pass-through of ALU results; accept or reject memory ops
// BUS   | request on the data bus, waiting for ack
// DONE  | write-back presented, pipeline released, inputs ignored
`ifndef AluOpBus
`define AluOpBus 8
`endif
`ifndef RegBus
`define RegBus 32
`endif
`ifndef RegAddrBus
`define RegAddrBus 5
`endif
`ifndef ALU_OP_NOP
`define ALU_OP_NOP 8'h00
`define ALU_OP_ADD 8'h20
`define ALU_OP_LB  8'hE0
`define ALU_OP_LH  8'hE1
`define ALU_OP_LW  8'hE3
`define ALU_OP_SB  8'hE8
`define ALU_OP_SH  8'hE9
`define ALU_OP_SW  8'hEB
`endif

module mem_lsu (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`AluOpBus-1:0]    aluop_i,
    input  logic [`RegBus-1:0]      mem_addr_i,
    input  logic [`RegBus-1:0]      reg2_i,
    input  logic [`RegAddrBus-1:0]  wd_i,
    input  logic                    wreg_i,
    input  logic [`RegBus-1:0]      wdata_i,
    output logic [`RegAddrBus-1:0]  wd_o,
    output logic                    wreg_o,
    output logic [`RegBus-1:0]      wdata_o,
    output logic                    stallreq,
    output logic                    addr_err_o,
    mem_lsu_if.master               dbus
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t                  state, state_n;
    logic [`AluOpBus-1:0]    op_q, op_n;
    logic [1:0]              off_q, off_n;
    logic [`RegAddrBus-1:0]  wd_q, wd_n;
    logic                    wreg_q, wreg_n;

    logic                    req_n, we_n;
    logic [3:0]              be_n;
    logic [`RegBus-1:0]      baddr_n, bwdata_n;
    logic [`RegAddrBus-1:0]  wd_o_n;
    logic                    wreg_o_n, addr_err_n, stall_c;
    logic [`RegBus-1:0]      wdata_o_n;

    logic                    is_load, is_store, aligned;
    logic [3:0]              be_c;
    logic [`RegBus-1:0]      st_data, ld_data;
    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        aligned  = 1'b1;
        be_c     = 4'b0000;
        st_data  = '0;
        case (aluop_i)
            `ALU_OP_LW, `ALU_OP_SW: begin
                is_load  = (aluop_i == `ALU_OP_LW);
                is_store = (aluop_i == `ALU_OP_SW);
                aligned  = (mem_addr_i[1:0] == 2'b00);
                be_c     = 4'b1111;
                st_data  = reg2_i;
            end
            `ALU_OP_LH, `ALU_OP_SH: begin
                is_load  = (aluop_i == `ALU_OP_LH);
                is_store = (aluop_i == `ALU_OP_SH);
                aligned  = ~mem_addr_i[0];
                be_c     = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{reg2_i[15:0]}};
            end
            `ALU_OP_LB, `ALU_OP_SB: begin
                is_load  = (aluop_i == `ALU_OP_LB);
                is_store = (aluop_i == `ALU_OP_SB);
                be_c     = 4'b0001 << mem_addr_i[1:0];
                st_data  = {4{reg2_i[7:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset latched at accept time, not the live address.
    always_comb begin
        ld_byte = dbus.dbus_rdata_i[8*off_q +: 8];
        ld_half = off_q[1] ? dbus.dbus_rdata_i[31:16] : dbus.dbus_rdata_i[15:0];
        case (op_q)
            `ALU_OP_LH: ld_data = {{16{ld_half[15]}}, ld_half};
            `ALU_OP_LB: ld_data = {{24{ld_byte[7]}}, ld_byte};
            default:    ld_data = dbus.dbus_rdata_i;
        endcase
    end

    always_comb begin
        state_n    = state;
        op_n       = op_q;
        off_n      = off_q;
        wd_n       = wd_q;
        wreg_n     = wreg_q;
        req_n      = dbus.dbus_req_o;
        we_n       = dbus.dbus_we_o;
        be_n       = dbus.dbus_be_o;
        baddr_n    = dbus.dbus_addr_o;
        bwdata_n   = dbus.dbus_wdata_o;
        wd_o_n     = wd_o;
        wreg_o_n   = 1'b0;
        wdata_o_n  = wdata_o;
        addr_err_n = 1'b0;
        stall_c    = 1'b0;
        case (state)
            IDLE: begin
                if (is_load || is_store) begin
                    if (aligned) begin
                        state_n  = BUS;
                        stall_c  = 1'b1;
                        op_n     = aluop_i;
                        off_n    = mem_addr_i[1:0];
                        wd_n     = wd_i;
                        wreg_n   = wreg_i & is_load;
                        req_n    = 1'b1;
                        we_n     = is_store;
                        be_n     = be_c;
                        baddr_n  = {mem_addr_i[31:2], 2'b00};
                        bwdata_n = st_data;
                    end else begin
                        addr_err_n = 1'b1;
                    end
                end else begin
                    wd_o_n    = wd_i;
                    wreg_o_n  = wreg_i;
                    wdata_o_n = wdata_i;
                end
            end
            BUS: begin
                stall_c = 1'b1;
                if (dbus.dbus_ack_i) begin
                    state_n = DONE;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    if (wreg_q) begin
                        wreg_o_n  = 1'b1;
                        wd_o_n    = wd_q;
                        wdata_o_n = ld_data;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Reset must drop the hold request at once, even while a memory op sits in EX.
    assign stallreq = rst & stall_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            op_q              <= `ALU_OP_NOP;
            off_q             <= 2'b00;
            wd_q              <= '0;
            wreg_q            <= 1'b0;
            dbus.dbus_req_o   <= 1'b0;
            dbus.dbus_we_o    <= 1'b0;
            dbus.dbus_be_o    <= 4'b0000;
            dbus.dbus_addr_o  <= '0;
            dbus.dbus_wdata_o <= '0;
            wd_o              <= '0;
            wreg_o            <= 1'b0;
            wdata_o           <= '0;
            addr_err_o        <= 1'b0;
        end else begin
            state             <= state_n;
            op_q              <= op_n;
            off_q             <= off_n;
            wd_q              <= wd_n;
            wreg_q            <= wreg_n;
            dbus.dbus_req_o   <= req_n;
            dbus.dbus_we_o    <= we_n;
            dbus.dbus_be_o    <= be_n;
            dbus.dbus_addr_o  <= baddr_n;
            dbus.dbus_wdata_o <= bwdata_n;
            wd_o              <= wd_o_n;
            wreg_o            <= wreg_o_n;
            wdata_o           <= wdata_o_n;
            addr_err_o        <= addr_err_n;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, aligned loads/stores, misalignment,
// spurious acks and reset during a bus access.
`ifndef ALU_OP_NOP
`define ALU_OP_NOP 8'h00
`define ALU_OP_ADD 8'h20
`define ALU_OP_LB  8'hE0
`define ALU_OP_LH  8'hE1
`define ALU_OP_LW  8'hE3
`define ALU_OP_SB  8'hE8
`define ALU_OP_SH  8'hE9
`define ALU_OP_SW  8'hEB
`endif

module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i, wdata_o;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, wreg_o, stallreq, addr_err_o;
    int          checks = 0;
    int          failures = 0;

    mem_lsu_if dbus_if ();

    mem_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq   (stallreq),
        .addr_err_o (addr_err_o),
        .dbus       (dbus_if)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete memory op: accept, nwait BUS cycles without ack, ack cycle, DONE.
    task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] rdata,
                           input int nwait, input logic [31:0] eaddr, input logic [3:0] ebe,
                           input logic ewe, input logic [31:0] ebus_wdata,
                           input logic ewreg, input logic [31:0] ewdata);
        int nstall;
        aluop_i = op; mem_addr_i = addr; reg2_i = r2; wd_i = wd; wreg_i = wreg;
        wdata_i = 32'h0; dbus_if.dbus_rdata_i = rdata; dbus_if.dbus_ack_i = 1'b0;
        #1;
        chk_val("stall_accept", stallreq, 1);
        nstall = 1;
        tick();
        chk_val("req_set", dbus_if.dbus_req_o, 1);
        chk_val("we", dbus_if.dbus_we_o, ewe);
        chk_val("be", dbus_if.dbus_be_o, ebe);
        chk_val("bus_addr", dbus_if.dbus_addr_o, eaddr);
        chk_val("wreg_accept", wreg_o, 0);
        if (ewe) chk_val("bus_wdata", dbus_if.dbus_wdata_o, ebus_wdata);
        for (int i = 0; i < nwait; i++) begin
            if (stallreq) nstall++;
            chk_val("req_hold", dbus_if.dbus_req_o, 1);
            tick();
        end
        dbus_if.dbus_ack_i = 1'b1;
        #1;
        if (stallreq) nstall++;
        chk_val("be_hold", dbus_if.dbus_be_o, ebe);
        tick();
        // DONE: ack stays high (spurious) and the held inputs change; both ignored.
        aluop_i = `ALU_OP_NOP; wreg_i = 1'b1; wdata_i = 32'h55; wd_i = 5'd31;
        #1;
        chk_val("req_clear", dbus_if.dbus_req_o, 0);
        chk_val("stall_done", stallreq, 0);
        chk_val("wreg_ack", wreg_o, ewreg);
        if (ewreg) begin
            chk_val("wd_ack", wd_o, wd);
            chk_val("wdata_ack", wdata_o, ewdata);
        end
        chk_val("stall_cycles", nstall, nwait + 2);
        tick();
        dbus_if.dbus_ack_i = 1'b0;
        chk_val("wreg_after_done", wreg_o, 0);
        chk_val("req_after_done", dbus_if.dbus_req_o, 0);
        wreg_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        aluop_i = `ALU_OP_NOP; mem_addr_i = 0; reg2_i = 0; wd_i = 0; wreg_i = 0; wdata_i = 0;
        dbus_if.dbus_rdata_i = 0; dbus_if.dbus_ack_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_req", dbus_if.dbus_req_o, 0);
        chk_val("rst_be", dbus_if.dbus_be_o, 0);
        chk_val("rst_addr", dbus_if.dbus_addr_o, 0);
        chk_val("rst_wreg", wreg_o, 0);
        chk_val("rst_wdata", wdata_o, 0);
        chk_val("rst_stall", stallreq, 0);
        rst = 1'b1;

        // ALU pass-through
        aluop_i = `ALU_OP_ADD; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h12;
        #1 chk_val("add_stall", stallreq, 0);
        tick();
        chk_val("add_wd", wd_o, 3);
        chk_val("add_wreg", wreg_o, 1);
        chk_val("add_wdata", wdata_o, 32'h12);
        chk_val("add_stall2", stallreq, 0);

        //       op          addr          reg2          wd  wr rdata         nw eaddr         be       we  bus_wdata     ewr ewdata
        mem_txn(`ALU_OP_LB, 32'h0000_1003, 32'h0,        7,  1, 32'h80FF_FFFF, 1, 32'h0000_1000, 4'b1000, 0, 32'h0,        1, 32'hFFFF_FF80);
        mem_txn(`ALU_OP_SH, 32'h0000_2002, 32'h0000_BEEF, 4, 0, 32'h0,         0, 32'h0000_2000, 4'b1100, 1, 32'hBEEF_BEEF, 0, 32'h0);
        mem_txn(`ALU_OP_SB, 32'h0000_3001, 32'h1234_5678, 2, 1, 32'h0,         2, 32'h0000_3000, 4'b0010, 1, 32'h7878_7878, 0, 32'h0);
        mem_txn(`ALU_OP_SW, 32'h0000_3004, 32'hCAFE_F00D, 2, 0, 32'h0,         0, 32'h0000_3004, 4'b1111, 1, 32'hCAFE_F00D, 0, 32'h0);
        mem_txn(`ALU_OP_LH, 32'h0000_0012, 32'h0,        9,  1, 32'h7FFF_8001, 0, 32'h0000_0010, 4'b1100, 0, 32'h0,        1, 32'h0000_7FFF);
        mem_txn(`ALU_OP_LH, 32'h0000_0010, 32'h0,        10, 1, 32'h7FFF_8001, 0, 32'h0000_0010, 4'b0011, 0, 32'h0,        1, 32'hFFFF_8001);
        mem_txn(`ALU_OP_LB, 32'h0000_0001, 32'h0,        11, 1, 32'h0000_7F00, 0, 32'h0000_0000, 4'b0010, 0, 32'h0,        1, 32'h0000_007F);
        mem_txn(`ALU_OP_LW, 32'h0000_0008, 32'h0,        12, 1, 32'hDEAD_BEEF, 1, 32'h0000_0008, 4'b1111, 0, 32'h0,        1, 32'hDEAD_BEEF);
        mem_txn(`ALU_OP_LW, 32'h0000_0004, 32'h0,        13, 0, 32'hDEAD_BEEF, 0, 32'h0000_0004, 4'b1111, 0, 32'h0,        0, 32'h0);

        // Spurious ack in IDLE
        aluop_i = `ALU_OP_NOP; wreg_i = 1'b0; dbus_if.dbus_ack_i = 1'b1;
        tick();
        dbus_if.dbus_ack_i = 1'b0;
        chk_val("idle_ack_req", dbus_if.dbus_req_o, 0);
        chk_val("idle_ack_wreg", wreg_o, 0);
        chk_val("idle_ack_stall", stallreq, 0);

        // Misaligned accesses
        aluop_i = `ALU_OP_LW; mem_addr_i = 32'h6; wd_i = 5'd5; wreg_i = 1'b1;
        #1 chk_val("mis_lw_stall", stallreq, 0);
        tick();
        chk_val("mis_lw_err", addr_err_o, 1);
        chk_val("mis_lw_req", dbus_if.dbus_req_o, 0);
        chk_val("mis_lw_wreg", wreg_o, 0);
        aluop_i = `ALU_OP_SH; mem_addr_i = 32'h2003;
        tick();
        chk_val("mis_sh_err", addr_err_o, 1);
        chk_val("mis_sh_req", dbus_if.dbus_req_o, 0);
        aluop_i = `ALU_OP_NOP; wreg_i = 1'b0;
        tick();
        chk_val("err_pulse_end", addr_err_o, 0);

        // Reset during BUS without ack
        aluop_i = `ALU_OP_LW; mem_addr_i = 32'h100; wd_i = 5'd6; wreg_i = 1'b1;
        tick();
        chk_val("abort_req_pre", dbus_if.dbus_req_o, 1);
        rst = 1'b0;
        #1;
        chk_val("abort_req", dbus_if.dbus_req_o, 0);
        chk_val("abort_stall", stallreq, 0);
        chk_val("abort_be", dbus_if.dbus_be_o, 0);
        chk_val("abort_addr", dbus_if.dbus_addr_o, 0);
        tick();
        aluop_i = `ALU_OP_ADD; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h12;
        rst = 1'b1;
        #1 chk_val("post_rst_stall", stallreq, 0);
        tick();
        chk_val("post_rst_wd", wd_o, 3);
        chk_val("post_rst_wreg", wreg_o, 1);
        chk_val("post_rst_wdata", wdata_o, 32'h12);
        chk_val("post_rst_req", dbus_if.dbus_req_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
